// File: rtl/adma_dm_dst_axis.sv
// adma_dm_dst_axis: destination-side AXI-Stream data mover.
// Queues per-transaction info (id/len/dest), streams DMA buffer beats out as an
// AXIS master with TID/TDEST per transaction and TLAST on the final beat, and
// pulses atx_done when the TLAST beat is taken by the sink.
// Optional feature macro: ADMA_DST_PARTIAL_LAST_EN (partial TKEEP/TSTRB on the TLAST beat).
module adma_dm_dst_axis #(
   parameter int unsigned DMA_CHN_NUM      = 4,
   parameter int unsigned ATX_DST_DATA_W   = 256,
   parameter int unsigned ATX_DST_BYTE_AMT = ATX_DST_DATA_W / 8,
   parameter int unsigned DST_TDEST_W      = 2,
   parameter int unsigned MST_ID_W         = 5,
   parameter int unsigned ATX_LEN_W        = 8,
   parameter int unsigned ATX_NUM_OSTD     = DMA_CHN_NUM
) (
   input  logic                          aclk,
   input  logic                          areset,
   input  logic [MST_ID_W-1:0]           atx_awid,
   input  logic [ATX_LEN_W-1:0]          atx_awlen,
   input  logic [DST_TDEST_W-1:0]        atx_awdest,
`ifdef ADMA_DST_PARTIAL_LAST_EN
   input  logic [$clog2(ATX_DST_BYTE_AMT)-1:0] atx_awlbytes,
`endif
   input  logic                          atx_vld,
   output logic                          atx_rdy,
   input  logic [ATX_DST_DATA_W-1:0]     atx_wdata,
   input  logic                          atx_wdata_vld,
   output logic                          atx_wdata_rdy,
   output logic                          atx_done,
   output logic [MST_ID_W-1:0]           atx_done_id,
   output logic [DMA_CHN_NUM-1:0]        atx_dst_err,
   output logic [MST_ID_W-1:0]           m_tid_o,
   output logic [DST_TDEST_W-1:0]        m_tdest_o,
   output logic [ATX_DST_DATA_W-1:0]     m_tdata_o,
   output logic [ATX_DST_BYTE_AMT-1:0]   m_tkeep_o,
   output logic [ATX_DST_BYTE_AMT-1:0]   m_tstrb_o,
   output logic                          m_tlast_o,
   output logic                          m_tvalid_o,
   input  logic                          m_tready_i
);

   localparam int unsigned PTR_W = (ATX_NUM_OSTD > 1) ? $clog2(ATX_NUM_OSTD) : 1;
   localparam int unsigned CNT_W = $clog2(ATX_NUM_OSTD + 1);
`ifdef ADMA_DST_PARTIAL_LAST_EN
   localparam int unsigned LB_W  = $clog2(ATX_DST_BYTE_AMT);
`endif

   // info FIFO storage and control
   logic [MST_ID_W-1:0]    id_q   [ATX_NUM_OSTD];
   logic [ATX_LEN_W-1:0]   len_q  [ATX_NUM_OSTD];
   logic [DST_TDEST_W-1:0] dest_q [ATX_NUM_OSTD];
`ifdef ADMA_DST_PARTIAL_LAST_EN
   logic [LB_W-1:0]        lb_q   [ATX_NUM_OSTD];
`endif
   logic [PTR_W-1:0]       wr_ptr;
   logic [PTR_W-1:0]       rd_ptr;
   logic [CNT_W-1:0]       fifo_cnt;
   logic                   fifo_full;
   logic                   fifo_empty;
   logic                   push;
   logic                   pop;

   logic [ATX_LEN_W-1:0]        beat_cnt;
   logic                        out_en;
   logic                        beat_acc;
   logic                        last_beat;
   logic [ATX_DST_BYTE_AMT-1:0] keep_c;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(ATX_NUM_OSTD - 1)) ? '0 : PTR_W'(p + PTR_W'(1));
   endfunction

   assign fifo_full  = (fifo_cnt == CNT_W'(ATX_NUM_OSTD));
   assign fifo_empty = (fifo_cnt == '0);
   assign atx_rdy    = ~fifo_full & ~areset;
   assign push       = atx_vld & atx_rdy;

   assign out_en        = ~m_tvalid_o | m_tready_i;
   assign atx_wdata_rdy = ~fifo_empty & out_en;
   assign beat_acc      = atx_wdata_vld & atx_wdata_rdy;
   assign last_beat     = (beat_cnt == len_q[rd_ptr]);
   assign pop           = beat_acc & last_beat;

   assign atx_done    = m_tvalid_o & m_tready_i & m_tlast_o;
   assign atx_done_id = m_tid_o;
   assign atx_dst_err = '0;
   assign m_tstrb_o   = m_tkeep_o;

   // FIFO payload write (no reset needed; validity tracked by pointers/count)
   always_ff @(posedge aclk) begin
      if (push) begin
         id_q[wr_ptr]   <= atx_awid;
         len_q[wr_ptr]  <= atx_awlen;
         dest_q[wr_ptr] <= atx_awdest;
`ifdef ADMA_DST_PARTIAL_LAST_EN
         lb_q[wr_ptr]   <= atx_awlbytes;
`endif
      end
   end

   // FIFO pointers and occupancy
   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         fifo_cnt <= '0;
      end else begin
         if (push) wr_ptr <= ptr_inc(wr_ptr);
         if (pop)  rd_ptr <= ptr_inc(rd_ptr);
         case ({push, pop})
            2'b10:   fifo_cnt <= fifo_cnt + CNT_W'(1);
            2'b01:   fifo_cnt <= fifo_cnt - CNT_W'(1);
            default: fifo_cnt <= fifo_cnt;
         endcase
      end
   end

   // beat counter within the head transaction
   always_ff @(posedge aclk or posedge areset) begin
      if (areset)        beat_cnt <= '0;
      else if (pop)      beat_cnt <= '0;
      else if (beat_acc) beat_cnt <= beat_cnt + ATX_LEN_W'(1);
   end

   // byte-enable mask for the beat being accepted
`ifdef ADMA_DST_PARTIAL_LAST_EN
   always_comb begin
      keep_c = '1;
      if (last_beat && (lb_q[rd_ptr] != '0)) begin
         for (int i = 0; i < int'(ATX_DST_BYTE_AMT); i++)
            keep_c[i] = (LB_W'(i) < lb_q[rd_ptr]);
      end
   end
`else
   always_comb begin
      keep_c = '1;
   end
`endif

   // single output register stage with full throughput
   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         m_tvalid_o <= 1'b0;
         m_tdata_o  <= '0;
         m_tid_o    <= '0;
         m_tdest_o  <= '0;
         m_tlast_o  <= 1'b0;
         m_tkeep_o  <= '0;
      end else if (out_en) begin
         m_tvalid_o <= beat_acc;
         if (beat_acc) begin
            m_tdata_o <= atx_wdata;
            m_tid_o   <= id_q[rd_ptr];
            m_tdest_o <= dest_q[rd_ptr];
            m_tlast_o <= last_beat;
            m_tkeep_o <= keep_c;
         end
      end
   end

endmodule
